// File: rtl/life_tracker.sv
// life_tracker: player life bookkeeping for the game-state FSM.
// Counts lives, takes at most one ship/meteor hit per video frame, runs a
// post-hit invulnerability window with a sprite blink, and raises a sticky
// player_die once the last life is gone. start_screen re-arms everything.
// Optional build macro: LIFE_TRACKER_EXTRA_LIFE_EN adds the bonus_pickup
// input, which grants an extra life (saturating at MAX_LIVES).

module life_tracker #(
    parameter int START_LIVES   = 3,
    parameter int MAX_LIVES     = 7,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_tick,
    input  logic                           collision,
    input  logic                           start_screen,
    input  logic                           game_screen,
`ifdef LIFE_TRACKER_EXTRA_LIFE_EN
    input  logic                           bonus_pickup,
`endif
    output logic                           player_die,
    output logic [$clog2(MAX_LIVES+1)-1:0] lives,
    output logic                           invincible,
    output logic                           blink
);

    localparam int LIVES_W = $clog2(MAX_LIVES + 1);
    localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ALIVE,
        INVULN,
        DEAD
    } state_t;

    state_t             state;
    logic [INV_W-1:0]   inv_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    logic               hit;
    logic               bonus;
    logic [LIVES_W-1:0] lives_up;

    // Frame-qualified hit/bonus events and the saturating increment of lives.
    always_comb begin
        hit = frame_tick & collision;
`ifdef LIFE_TRACKER_EXTRA_LIFE_EN
        bonus = frame_tick & bonus_pickup;
`else
        bonus = 1'b0;
`endif
        lives_up = (lives >= LIVES_W'(MAX_LIVES)) ? lives : lives + LIVES_W'(1);
    end

    // Life-tracking state machine; every output is registered here.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            lives      <= LIVES_W'(START_LIVES);
            player_die <= 1'b0;
            invincible <= 1'b0;
            blink      <= 1'b1;
            inv_cnt    <= '0;
            blink_cnt  <= '0;
        end else if (start_screen) begin
            state      <= IDLE;
            lives      <= LIVES_W'(START_LIVES);
            player_die <= 1'b0;
            invincible <= 1'b0;
            blink      <= 1'b1;
            inv_cnt    <= '0;
            blink_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    player_die <= 1'b0;
                    invincible <= 1'b0;
                    blink      <= 1'b1;
                    if (game_screen) begin
                        state <= ALIVE;
                    end
                end

                ALIVE: begin
                    if (!game_screen) begin
                        state      <= IDLE;
                        invincible <= 1'b0;
                        blink      <= 1'b1;
                    end else if (hit && bonus) begin
                        state      <= INVULN;
                        inv_cnt    <= INV_W'(INVULN_FRAMES);
                        blink_cnt  <= BLINK_W'(BLINK_FRAMES);
                        invincible <= 1'b1;
                        blink      <= 1'b0;
                    end else if (hit) begin
                        if (lives > LIVES_W'(1)) begin
                            lives      <= lives - LIVES_W'(1);
                            state      <= INVULN;
                            inv_cnt    <= INV_W'(INVULN_FRAMES);
                            blink_cnt  <= BLINK_W'(BLINK_FRAMES);
                            invincible <= 1'b1;
                            blink      <= 1'b0;
                        end else begin
                            lives      <= '0;
                            state      <= DEAD;
                            player_die <= 1'b1;
                            invincible <= 1'b0;
                            blink      <= 1'b0;
                        end
                    end else if (bonus) begin
                        lives <= lives_up;
                    end
                end

                INVULN: begin
                    if (!game_screen) begin
                        state      <= IDLE;
                        invincible <= 1'b0;
                        blink      <= 1'b1;
                        inv_cnt    <= '0;
                        blink_cnt  <= '0;
                    end else if (frame_tick) begin
                        if (bonus) begin
                            lives <= lives_up;
                        end
                        if (inv_cnt <= INV_W'(1)) begin
                            state      <= ALIVE;
                            invincible <= 1'b0;
                            blink      <= 1'b1;
                            inv_cnt    <= '0;
                            blink_cnt  <= '0;
                        end else begin
                            inv_cnt <= inv_cnt - INV_W'(1);
                            if (blink_cnt <= BLINK_W'(1)) begin
                                blink     <= ~blink;
                                blink_cnt <= BLINK_W'(BLINK_FRAMES);
                            end else begin
                                blink_cnt <= blink_cnt - BLINK_W'(1);
                            end
                        end
                    end
                end

                DEAD: begin
                    player_die <= 1'b1;
                    lives      <= '0;
                    invincible <= 1'b0;
                    blink      <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_tracker.sv
// tb_life_tracker: directed, self-checking bench for life_tracker.
// Expected values are hand-derived from the default parameters
// (START_LIVES=3, MAX_LIVES=7, INVULN_FRAMES=120, BLINK_FRAMES=8).

module tb_life_tracker;

    localparam int START_LIVES   = 3;
    localparam int MAX_LIVES     = 7;
    localparam int INVULN_FRAMES = 120;
    localparam int BLINK_FRAMES  = 8;

    logic       Clk          = 1'b0;
    logic       Reset        = 1'b1;
    logic       frame_tick   = 1'b0;
    logic       collision    = 1'b0;
    logic       start_screen = 1'b0;
    logic       game_screen  = 1'b0;
`ifdef LIFE_TRACKER_EXTRA_LIFE_EN
    logic       bonus_pickup = 1'b0;
`endif
    logic       player_die;
    logic [2:0] lives;
    logic       invincible;
    logic       blink;

    int compared   = 0;
    int mismatched = 0;

    // 100 MHz-style free-running clock.
    always #5 Clk = ~Clk;

    life_tracker #(
        .START_LIVES  (START_LIVES),
        .MAX_LIVES    (MAX_LIVES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .collision   (collision),
        .start_screen(start_screen),
        .game_screen (game_screen),
`ifdef LIFE_TRACKER_EXTRA_LIFE_EN
        .bonus_pickup(bonus_pickup),
`endif
        .player_die  (player_die),
        .lives       (lives),
        .invincible  (invincible),
        .blink       (blink)
    );

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive on the falling edge, let the rising edge sample,
    // then return 1 time unit after the rising edge with pulses cleared.
    task automatic applyStimulus(input logic tick, input logic coll,
                                 input logic start, input logic game);
        @(negedge Clk);
        frame_tick   = tick;
        collision    = coll;
        start_screen = start;
        game_screen  = game;
        @(posedge Clk);
        #1;
        frame_tick   = 1'b0;
        collision    = 1'b0;
        start_screen = 1'b0;
    endtask

`ifdef LIFE_TRACKER_EXTRA_LIFE_EN
    // Same as applyStimulus with a bonus pulse in the same cycle.
    task automatic apply_bonus(input logic tick, input logic coll);
        bonus_pickup = 1'b1;
        applyStimulus(tick, coll, 1'b0, 1'b1);
        bonus_pickup = 1'b0;
    endtask
`endif

    // Full invulnerability window with collision held high; one tick every
    // 4 clocks. Blink toggles on ticks 8,16,...; tick 120 ends the window.
    task automatic run_invuln(input int lives_exp);
        int blink_exp;
        int inv_exp;
        blink_exp = 0;
        inv_exp   = 1;
        for (int t = 1; t <= INVULN_FRAMES; t++) begin
            repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            if (t == INVULN_FRAMES) begin
                blink_exp = 1;
                inv_exp   = 0;
            end else if (t % BLINK_FRAMES == 0) begin
                blink_exp = 1 - blink_exp;
            end
            checkOutput($sformatf("invuln_blink_t%0d", t), int'(blink), blink_exp);
            checkOutput($sformatf("invuln_flag_t%0d", t), int'(invincible), inv_exp);
            checkOutput($sformatf("invuln_lives_t%0d", t), int'(lives), lives_exp);
        end
    endtask

    // Start pulse followed by entry into the game.
    task automatic start_game();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Directed test sequence.
    initial begin
        // Asynchronous reset, checked before any clock edge.
        #3 Reset = 1'b0;
        #1;
        checkOutput("rst_lives", int'(lives), 3);
        checkOutput("rst_die", int'(player_die), 0);
        checkOutput("rst_inv", int'(invincible), 0);
        checkOutput("rst_blink", int'(blink), 1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        // IDLE ignores hits.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_no_hit", int'(lives), 3);

        // Enter game; collision without a tick is ignored.
        start_game();
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("no_tick_lives", int'(lives), 3);
        checkOutput("no_tick_inv", int'(invincible), 0);

        // First hit.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("hit1_lives", int'(lives), 2);
        checkOutput("hit1_inv", int'(invincible), 1);
        checkOutput("hit1_blink", int'(blink), 0);
        run_invuln(2);

        // Second hit, then asynchronous reset mid-window with lives=1.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("hit2_lives", int'(lives), 1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_inv_flag", int'(invincible), 1);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        checkOutput("midrst_lives", int'(lives), 3);
        checkOutput("midrst_inv", int'(invincible), 0);
        checkOutput("midrst_blink", int'(blink), 1);
        checkOutput("midrst_die", int'(player_die), 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Three separate hits down to death.
        start_game();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("d_hit1_lives", int'(lives), 2);
        run_invuln(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("d_hit2_lives", int'(lives), 1);
        run_invuln(1);
        checkOutput("pre_death_die", int'(player_die), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("death_die", int'(player_die), 1);
        checkOutput("death_lives", int'(lives), 0);
        checkOutput("death_blink", int'(blink), 0);
        checkOutput("death_inv", int'(invincible), 0);
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1 * (i % 4 == 0), 1'b1 * (i % 3 == 0), 1'b0, 1'b1);
            if (i % 250 == 249) checkOutput($sformatf("dead_hold_%0d", i), int'(player_die), 1);
        end
        checkOutput("dead_hold_lives", int'(lives), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rearm_die", int'(player_die), 0);
        checkOutput("rearm_lives", int'(lives), 3);
        checkOutput("rearm_blink", int'(blink), 1);

        // start_screen beats a same-cycle hit in ALIVE.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("start_hit_lives", int'(lives), 3);
        checkOutput("start_hit_inv", int'(invincible), 0);
        checkOutput("start_hit_die", int'(player_die), 0);

        // start_screen during INVULN reloads lives and clears the window.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("pre_start_lives", int'(lives), 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("start_inv_lives", int'(lives), 3);
        checkOutput("start_inv_flag", int'(invincible), 0);
        checkOutput("start_inv_blink", int'(blink), 1);

        // Leaving the game mid-window keeps lives; IDLE then ignores hits.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("leave_lives", int'(lives), 2);
        checkOutput("leave_inv", int'(invincible), 0);
        checkOutput("leave_blink", int'(blink), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("leave_idle_hit", int'(lives), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("return_hit_lives", int'(lives), 1);

`ifdef LIFE_TRACKER_EXTRA_LIFE_EN
        // Bonus pickups saturate at MAX_LIVES.
        start_game();
        for (int i = 0; i < 7; i++) begin
            apply_bonus(1'b1, 1'b0);
            checkOutput($sformatf("bonus_%0d", i), int'(lives), (4 + i > 7) ? 7 : 4 + i);
        end
        // Bonus without a tick is ignored.
        start_game();
        apply_bonus(1'b0, 1'b0);
        checkOutput("bonus_no_tick", int'(lives), 3);
        // Reach lives=1, then hit and bonus on the same tick.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        run_invuln(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        run_invuln(1);
        apply_bonus(1'b1, 1'b1);
        checkOutput("hit_bonus_lives", int'(lives), 1);
        checkOutput("hit_bonus_inv", int'(invincible), 1);
        checkOutput("hit_bonus_die", int'(player_die), 0);
        apply_bonus(1'b1, 1'b1);
        checkOutput("invuln_bonus_lives", int'(lives), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
